// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier running on the 27 MHz reference clock.
// Holds the PLL in reset, waits for a stable synchronized LOCK, then releases the system reset.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES  = 270,
  parameter int unsigned LOCK_TIMEOUT   = 27000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             lock_in,
  input  logic             force_relock,
  input  logic             clr_counts,
  output logic             pll_reset,
  output logic             sys_rst_n,
  output logic             locked,
  output logic             lol_pulse,
  output logic [CNT_W-1:0] lol_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [1:0]       state
);

  localparam int unsigned HoldW   = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned StableW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TimerW  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [HoldW-1:0]   HoldLast    = HoldW'(PLL_RST_CYCLES - 1);
  localparam logic [StableW-1:0] StableLast  = StableW'(STABLE_CYCLES - 1);
  localparam logic [TimerW-1:0]  TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StStable   = 2'd2,
    StRun      = 2'd3
  } state_e;

  state_e              state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [HoldW-1:0]    hold_q;
  logic [StableW-1:0]  stable_q;
  logic [TimerW-1:0]   timer_q;
  logic                pll_reset_q;
  logic                locked_q;
  logic                lol_pulse_q;
  logic [CNT_W-1:0]    lol_count_q;
  logic [CNT_W-1:0]    timeout_count_q;

  logic lock_s;
  logic timeout_hit;
  logic stable_done;
  logic lol_evt;
  logic timeout_evt;

  // LOCK is asynchronous to clkin; only the last synchronizer stage is ever used.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Stable completion beats a coincident timeout; force_relock suppresses both events.
  always_comb begin
    timeout_hit = 1'b0;
    stable_done = 1'b0;
    lol_evt     = 1'b0;
    timeout_evt = 1'b0;
    if (state_q == StWaitLock || state_q == StStable) begin
      timeout_hit = (timer_q == TimeoutLast);
    end
    if (state_q == StStable) begin
      stable_done = lock_s && (stable_q == StableLast);
    end
    if (!force_relock) begin
      lol_evt     = (state_q == StRun) && !lock_s;
      timeout_evt = timeout_hit && !stable_done;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPllRst;
      hold_q      <= '0;
      stable_q    <= '0;
      timer_q     <= '0;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      lol_pulse_q <= 1'b0;
    end else begin
      lol_pulse_q <= 1'b0;
      if (force_relock) begin
        state_q     <= StPllRst;
        hold_q      <= '0;
        stable_q    <= '0;
        pll_reset_q <= 1'b1;
        locked_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StPllRst: begin
            if (hold_q == HoldLast) begin
              state_q     <= StWaitLock;
              hold_q      <= '0;
              timer_q     <= '0;
              pll_reset_q <= 1'b0;
            end else begin
              hold_q <= hold_q + HoldW'(1);
            end
          end
          StWaitLock: begin
            timer_q <= timer_q + TimerW'(1);
            if (timeout_hit) begin
              state_q     <= StPllRst;
              hold_q      <= '0;
              pll_reset_q <= 1'b1;
            end else if (lock_s) begin
              state_q  <= StStable;
              stable_q <= StableW'(1);
            end
          end
          StStable: begin
            // Timer keeps running across bounces so a chattering lock still times out.
            timer_q <= timer_q + TimerW'(1);
            if (stable_done) begin
              state_q  <= StRun;
              locked_q <= 1'b1;
            end else if (timeout_hit) begin
              state_q     <= StPllRst;
              hold_q      <= '0;
              stable_q    <= '0;
              pll_reset_q <= 1'b1;
            end else if (!lock_s) begin
              state_q  <= StWaitLock;
              stable_q <= '0;
            end else begin
              stable_q <= stable_q + StableW'(1);
            end
          end
          StRun: begin
            if (!lock_s) begin
              state_q     <= StWaitLock;
              timer_q     <= '0;
              stable_q    <= '0;
              locked_q    <= 1'b0;
              lol_pulse_q <= 1'b1;
            end
          end
          default: begin
            state_q <= StPllRst;
          end
        endcase
      end
    end
  end

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clr);
    if (clr) begin
      return inc ? CNT_W'(1) : '0;
    end
    if (inc && (cnt != '1)) begin
      return cnt + CNT_W'(1);
    end
    return cnt;
  endfunction

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lol_count_q     <= '0;
      timeout_count_q <= '0;
    end else begin
      lol_count_q     <= cnt_next(lol_count_q, lol_evt, clr_counts);
      timeout_count_q <= cnt_next(timeout_count_q, timeout_evt, clr_counts);
    end
  end

  assign pll_reset     = pll_reset_q;
  assign locked        = locked_q;
  assign sys_rst_n     = locked_q;
  assign lol_pulse     = lol_pulse_q;
  assign lol_count     = lol_count_q;
  assign timeout_count = timeout_count_q;
  assign state         = state_q;

endmodule
